weight_pingpong_buffer: RTL and testbench
=========================================

// Module: weight_pingpong_buffer
// PURPOSE
//  Parametrised double-buffered weight fetch controller between main controller, weight memory and PE arrays.
//  Computes the fetch address and issues a level request, then captures N_ELEM words into one of two banks.
//  Serves the oldest full bank to the PEs on start, so the next fetch overlaps with compute.
//  Adds a half/full kernel mode and a sticky protocol-error flag.
// PARAMETERS
//  DATA_W  16  width of one weight word
//  N_ELEM  18  words per memory beat / per bank (must be even)
//  ADDR_W  16  memory address width
//  DIM_W   8   width of od/total_od fields
//  ID_W    4   width of id/total_id fields
// PORTS
//  clk               in   1               clock, all logic on rising edge
//  reset_n           in   1               asynchronous active-low reset
//  cfg_wen_i         in   1               latch cfg_* fields this cycle
//  cfg_total_id_i    in   ID_W            layer input depth
//  cfg_total_od_i    in   DIM_W           layer output depth (address stride)
//  cfg_size_type_i   in   1               0: half kernel (N_ELEM/2 words), 1: full (N_ELEM words)
//  prepare_i         in   1               request a bank fill for (od_i, id_i)
//  od_i              in   DIM_W           output-depth index of fill
//  id_i              in   ID_W            input-depth index of fill
//  prepare_ready_o   out  1               prepare_i will be accepted this cycle
//  start_i           in   1               activate oldest FULL bank
//  release_i         in   1               free the ACTIVE bank
//  ready_o           out  1               at least one FULL bank waiting
//  weight_addr_o     out  ADDR_W          registered fetch address
//  weight_request_o  out  1               fetch request, held until weight_valid_i
//  weight_data_i     in   DATA_W x N_ELEM memory data beat
//  weight_valid_i    in   1               weight_data_i valid; completes the request
//  weight_o          out  DATA_W x N_ELEM contents of ACTIVE bank
//  weight_valid_o    out  1               a bank is ACTIVE
//  err_o             out  1               sticky protocol error
// BEHAVIOUR
//  Reset (async, reset_n=0): cfg regs 0; both banks EMPTY, data 0; wr_ptr=rd_ptr=0; fetch FSM IDLE.
//   Outputs: request/addr/ready/weight_valid/err = 0, weight_o = 0, prepare_ready_o = 1.
//   An in-flight request is dropped; a late weight_valid_i after reset sets err_o.
//  Config: cfg_* registered on cfg_wen_i; an already registered weight_addr_o is not affected.
//  Bank state per bank: EMPTY -> FILL -> FULL -> ACTIVE -> EMPTY. Banks fill at wr_ptr and activate at rd_ptr.
//   Both pointers toggle, so banks are used in strict FIFO order.
//  Fetch FSM: IDLE, REQ.
//   prepare_ready_o = IDLE && bank[wr_ptr]==EMPTY (combinational).
//   Accepted prepare_i (cycle t):
//    weight_addr_o <= od_i + cfg_total_od*id_i, computed at DIM_W+ID_W+1 bits, zero-extended/truncated to ADDR_W.
//    weight_request_o = 1 from t+1.
//    bank[wr_ptr] becomes FILL, and the FSM moves to REQ.
//   In REQ, request_o and addr_o are held stable until weight_valid_i=1 (cycle v).
//    At v, weight_data_i is captured into bank[wr_ptr].
//    If cfg_size_type=0, words N_ELEM/2..N_ELEM-1 are stored as 0.
//   At v+1: bank FULL, wr_ptr toggled, request_o=0, FSM IDLE.
//    ready_o=1 and prepare_ready_o reflect the new state at v+1.
//    A new prepare is possible at v+1, so back-to-back fills are allowed.
//  start_i with ready_o=1 (cycle s):
//   Any ACTIVE bank becomes EMPTY (implicit release).
//   bank[rd_ptr] becomes ACTIVE and rd_ptr toggles.
//   weight_o/weight_valid_o update at s+1.
//  release_i with a bank ACTIVE: that bank becomes EMPTY at next edge; weight_valid_o=0 and weight_o=0.
//   If start_i and release_i are high together, start wins (a swap, no gap in weight_valid_o).
//  Simultaneous weight_valid_i and start_i/release_i on different banks: all take effect in the same edge.
//  err_o set (sticky until reset) on any of:
//   prepare_i && !prepare_ready_o (request ignored);
//   start_i && !ready_o (ignored);
//   weight_valid_i in IDLE (data discarded);
//   release_i with no ACTIVE bank (ignored).
//  Full condition: both banks FULL/ACTIVE, so prepare_ready_o=0.
//  Empty condition: no FULL bank, so ready_o=0.
// TESTING
//  T1 reset: reset_n=0 mid-REQ -> request_o=0, addr=0, banks EMPTY, prepare_ready_o=1, err_o=0 immediately.
//  T2 address: total_od=20, prepare od=3,id=5 -> addr_o=103 at t+1, request_o held high until valid.
//   Then ready_o=1 at v+1.
//  T3 ping-pong: fill A(data k), fill B(data k+100), start -> weight_o=A.
//   prepare_ready_o=0; start again -> weight_o=B, no valid gap.
//   Then prepare_ready_o=1.
//  T4 half mode: size_type=0, data words 1..18 -> words 0-8 = 1..9, words 9-17 = 0 in weight_o.
//  T5 overlap: start bank A in the same cycle as weight_valid_i for bank B.
//   -> weight_valid_o=1 and ready_o=1 next cycle, err_o=0.
//  T6 errors: start with no FULL bank; stray weight_valid_i in IDLE; prepare while full.
//   -> err_o=1 and stays 1; bank states unchanged.

Source files
------------

// File: rtl/weight_pingpong_buffer_if.sv
// Memory-side fetch bus of the weight ping-pong buffer: the buffer drives
// address/request and the weight memory returns one beat with valid.
interface weight_pingpong_buffer_if #(
  parameter int DATA_W = 16,
  parameter int N_ELEM = 18,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0]              addr;
  logic                           request;
  logic [N_ELEM-1:0][DATA_W-1:0]  data;
  logic                           valid;

  modport master (output addr, request, input data, valid);
  modport slave  (input addr, request, output data, valid);
endinterface

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight fetch controller: fills two banks from weight memory in
// FIFO order and presents the oldest full bank to the PE arrays.

module weight_pp_bank #(
  parameter int DATA_W = 16,
  parameter int N_ELEM = 18
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          load_i,
  input  logic                          half_i,
  input  logic [N_ELEM-1:0][DATA_W-1:0] data_i,
  output logic [N_ELEM-1:0][DATA_W-1:0] data_o
);
  for (genvar w = 0; w < N_ELEM; w++) begin : g_word
    // Upper half of the kernel is zeroed when capturing a half-size kernel.
    localparam bit UPPER = (w >= N_ELEM / 2);
    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    word_q <= '0;
      else if (load_i) word_q <= (UPPER && half_i) ? '0 : data_i[w];
    end

    assign data_o[w] = word_q;
  end
endmodule

module weight_pingpong_buffer #(
  parameter int DATA_W = 16,
  parameter int N_ELEM = 18,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8,
  parameter int ID_W   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_wen_i,
  input  logic [ID_W-1:0]               cfg_total_id_i,
  input  logic [DIM_W-1:0]              cfg_total_od_i,
  input  logic                          cfg_size_type_i,
  input  logic                          prepare_i,
  input  logic [DIM_W-1:0]              od_i,
  input  logic [ID_W-1:0]               id_i,
  output logic                          prepare_ready_o,
  input  logic                          start_i,
  input  logic                          release_i,
  output logic                          ready_o,
  weight_pingpong_buffer_if.master      mem,
  output logic [N_ELEM-1:0][DATA_W-1:0] weight_o,
  output logic                          weight_valid_o,
  output logic                          err_o
);
  localparam int PW = DIM_W + ID_W + 1;

  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_ACTIVE} bank_st_e;
  typedef enum logic {F_IDLE, F_REQ} fetch_st_e;

  typedef logic [N_ELEM-1:0][DATA_W-1:0] wvec_t;

  logic [ID_W-1:0]   cfg_total_id_q;
  logic [DIM_W-1:0]  cfg_total_od_q;
  logic              cfg_size_type_q;

  bank_st_e          bank_q [2];
  bank_st_e          bank_d [2];
  fetch_st_e         fsm_q, fsm_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [1:0]        load;
  wvec_t             bank_data [2];

  logic              any_active, prep_ok, start_ok, rel_ok;
  logic [PW-1:0]     addr_calc;

  // Depth count is held for the controller but not needed by the fetch path.
  logic cfg_unused;
  assign cfg_unused = ^cfg_total_id_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_total_id_q  <= '0;
      cfg_total_od_q  <= '0;
      cfg_size_type_q <= 1'b0;
    end else if (cfg_wen_i) begin
      cfg_total_id_q  <= cfg_total_id_i;
      cfg_total_od_q  <= cfg_total_od_i;
      cfg_size_type_q <= cfg_size_type_i;
    end
  end

  assign any_active      = (bank_q[0] == B_ACTIVE) || (bank_q[1] == B_ACTIVE);
  assign prepare_ready_o = (fsm_q == F_IDLE) && (bank_q[wr_q] == B_EMPTY);
  assign ready_o         = (bank_q[rd_q] == B_FULL);
  assign prep_ok         = prepare_i && prepare_ready_o;
  assign start_ok        = start_i && ready_o;
  assign rel_ok          = release_i && !start_i && any_active;
  assign addr_calc       = PW'(od_i) + PW'(cfg_total_od_q) * PW'(id_i);

  always_comb begin
    bank_d = bank_q;
    fsm_d  = fsm_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    addr_d = addr_q;
    err_d  = err_q;
    load   = 2'b00;

    if ((prepare_i && !prepare_ready_o) || (start_i && !ready_o) ||
        (mem.valid && fsm_q == F_IDLE) || (release_i && !any_active))
      err_d = 1'b1;

    // Fetch side only ever touches bank[wr_q], which is EMPTY or FILL and so
    // never collides with the consumer-side updates below.
    case (fsm_q)
      F_IDLE: if (prep_ok) begin
        addr_d       = ADDR_W'(addr_calc);
        bank_d[wr_q] = B_FILL;
        fsm_d        = F_REQ;
      end
      F_REQ: if (mem.valid) begin
        load[wr_q]   = 1'b1;
        bank_d[wr_q] = B_FULL;
        wr_d         = ~wr_q;
        fsm_d        = F_IDLE;
      end
      default: fsm_d = F_IDLE;
    endcase

    if (start_ok) begin
      for (int b = 0; b < 2; b++)
        if (bank_q[b] == B_ACTIVE) bank_d[b] = B_EMPTY;
      bank_d[rd_q] = B_ACTIVE;
      rd_d         = ~rd_q;
    end else if (rel_ok) begin
      for (int b = 0; b < 2; b++)
        if (bank_q[b] == B_ACTIVE) bank_d[b] = B_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q[0] <= B_EMPTY;
      bank_q[1] <= B_EMPTY;
      fsm_q     <= F_IDLE;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      fsm_q     <= fsm_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    weight_pp_bank #(.DATA_W(DATA_W), .N_ELEM(N_ELEM)) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (load[b]),
      .half_i  (!cfg_size_type_q),
      .data_i  (mem.data),
      .data_o  (bank_data[b])
    );
  end

  always_comb begin
    weight_o = '0;
    for (int b = 0; b < 2; b++)
      if (bank_q[b] == B_ACTIVE) weight_o = bank_data[b];
  end

  assign weight_valid_o = any_active;
  assign err_o          = err_q;
  assign mem.addr       = addr_q;
  assign mem.request    = (fsm_q == F_REQ);
endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed bench for weight_pingpong_buffer: a vector table for address/fill/serve
// round trips plus hand sequences for reset, ping-pong, half mode, overlap, errors.
module tb_weight_pingpong_buffer;
  localparam int DATA_W = 16, N_ELEM = 18, ADDR_W = 16, DIM_W = 8, ID_W = 4;
  typedef logic [N_ELEM-1:0][DATA_W-1:0] wvec_t;

  typedef struct {
    logic [DIM_W-1:0]  total_od;
    logic [DIM_W-1:0]  od;
    logic [ID_W-1:0]   id;
    int                base;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  logic clk, reset_n, cfg_wen_i, cfg_size_type_i, prepare_i, start_i, release_i;
  logic [ID_W-1:0]  cfg_total_id_i, id_i;
  logic [DIM_W-1:0] cfg_total_od_i, od_i;
  logic prepare_ready_o, ready_o, weight_valid_o, err_o;
  wvec_t weight_o;

  int n_chk = 0, n_fail = 0;
  vec_t vecs [5];

  weight_pingpong_buffer_if #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .ADDR_W(ADDR_W)) mem_if ();

  weight_pingpong_buffer #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .ADDR_W(ADDR_W),
                           .DIM_W(DIM_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_wen_i(cfg_wen_i), .cfg_total_id_i(cfg_total_id_i),
    .cfg_total_od_i(cfg_total_od_i), .cfg_size_type_i(cfg_size_type_i),
    .prepare_i(prepare_i), .od_i(od_i), .id_i(id_i), .prepare_ready_o(prepare_ready_o),
    .start_i(start_i), .release_i(release_i), .ready_o(ready_o), .mem(mem_if),
    .weight_o(weight_o), .weight_valid_o(weight_valid_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic wvec_t mkdata(input int base, input bit half);
    wvec_t w;
    for (int k = 0; k < N_ELEM; k++)
      w[k] = (half && k >= N_ELEM / 2) ? '0 : DATA_W'(base + k);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input wvec_t act, input wvec_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input logic [DIM_W-1:0] tod, input logic size);
    cfg_wen_i = 1'b1; cfg_total_id_i = 4'd8; cfg_total_od_i = tod; cfg_size_type_i = size;
    tick();
    cfg_wen_i = 1'b0;
  endtask

  task automatic do_prepare(input logic [DIM_W-1:0] od, input logic [ID_W-1:0] id);
    prepare_i = 1'b1; od_i = od; id_i = id;
    tick();
    prepare_i = 1'b0;
  endtask

  task automatic do_valid(input wvec_t d);
    mem_if.data = d; mem_if.valid = 1'b1;
    tick();
    mem_if.valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic pulse_release();
    release_i = 1'b1; tick(); release_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'd20,  8'd3,   4'd5,  0,    16'd103};
    vecs[1] = '{8'd0,   8'd7,   4'd9,  200,  16'd7};
    vecs[2] = '{8'd255, 8'd255, 4'd15, 1000, 16'd4080};
    vecs[3] = '{8'd1,   8'd0,   4'd0,  500,  16'd0};
    vecs[4] = '{8'd16,  8'd2,   4'd3,  7,    16'd50};

    reset_n = 1'b0; cfg_wen_i = 0; cfg_total_id_i = 0; cfg_total_od_i = 0; cfg_size_type_i = 0;
    prepare_i = 0; od_i = 0; id_i = 0; start_i = 0; release_i = 0;
    mem_if.valid = 1'b0; mem_if.data = '0;

    #12;
    chk("rst_request", mem_if.request, 0);
    chk("rst_addr", mem_if.addr, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_wvalid", weight_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_prep_ready", prepare_ready_o, 1);
    chkw("rst_weight", weight_o, '0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Fill/serve/release round trip per vector; alternates banks each row.
    for (int i = 0; i < 5; i++) begin
      set_cfg(vecs[i].total_od, 1'b1);
      do_prepare(vecs[i].od, vecs[i].id);
      chk($sformatf("v%0d_addr", i), mem_if.addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_req", i), mem_if.request, 1);
      tick();
      chk($sformatf("v%0d_req_held", i), mem_if.request, 1);
      chk($sformatf("v%0d_addr_held", i), mem_if.addr, vecs[i].exp_addr);
      do_valid(mkdata(vecs[i].base, 0));
      chk($sformatf("v%0d_ready", i), ready_o, 1);
      chk($sformatf("v%0d_req_drop", i), mem_if.request, 0);
      pulse_start();
      chk($sformatf("v%0d_wvalid", i), weight_valid_o, 1);
      chkw($sformatf("v%0d_weight", i), weight_o, mkdata(vecs[i].base, 0));
      pulse_release();
      chk($sformatf("v%0d_wvalid_rel", i), weight_valid_o, 0);
      chkw($sformatf("v%0d_weight_rel", i), weight_o, '0);
      chk($sformatf("v%0d_err", i), err_o, 0);
    end

    // Reset in the middle of an outstanding request.
    set_cfg(8'd20, 1'b1);
    do_prepare(8'd3, 4'd5);
    chk("t1_req_before", mem_if.request, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_req", mem_if.request, 0);
    chk("t1_addr", mem_if.addr, 0);
    chk("t1_prep_ready", prepare_ready_o, 1);
    chk("t1_ready", ready_o, 0);
    chk("t1_err", err_o, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    do_valid(mkdata(9, 0));
    chk("t1_late_valid_err", err_o, 1);
    chk("t1_late_valid_ready", ready_o, 0);
    reset_n = 1'b0; #1;
    chk("t1_err_cleared", err_o, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Ping-pong across both banks.
    set_cfg(8'd20, 1'b1);
    do_prepare(8'd1, 4'd0); do_valid(mkdata(0, 0));
    do_prepare(8'd2, 4'd0); do_valid(mkdata(100, 0));
    chk("t3_full_prep_ready", prepare_ready_o, 0);
    chk("t3_full_ready", ready_o, 1);
    pulse_start();
    chkw("t3_weight_a", weight_o, mkdata(0, 0));
    chk("t3_wvalid_a", weight_valid_o, 1);
    chk("t3_prep_ready_a", prepare_ready_o, 0);
    pulse_start();
    chkw("t3_weight_b", weight_o, mkdata(100, 0));
    chk("t3_wvalid_b", weight_valid_o, 1);
    chk("t3_prep_ready_b", prepare_ready_o, 1);
    chk("t3_ready_b", ready_o, 0);
    pulse_release();
    chk("t3_wvalid_rel", weight_valid_o, 0);

    // Half kernel mode.
    set_cfg(8'd20, 1'b0);
    do_prepare(8'd0, 4'd1); do_valid(mkdata(1, 0));
    pulse_start();
    chkw("t4_weight_half", weight_o, mkdata(1, 1));
    chk("t4_word8", weight_o[8], 16'd9);
    chk("t4_word9", weight_o[9], 16'd0);
    chk("t4_word17", weight_o[17], 16'd0);
    pulse_release();
    set_cfg(8'd20, 1'b1);

    // Start one bank in the same edge the other bank completes.
    do_prepare(8'd4, 4'd0); do_valid(mkdata(300, 0));
    do_prepare(8'd5, 4'd0);
    start_i = 1'b1; mem_if.data = mkdata(400, 0); mem_if.valid = 1'b1;
    tick();
    start_i = 1'b0; mem_if.valid = 1'b0;
    chk("t5_wvalid", weight_valid_o, 1);
    chk("t5_ready", ready_o, 1);
    chk("t5_err", err_o, 0);
    chkw("t5_weight_a", weight_o, mkdata(300, 0));
    pulse_start();
    chkw("t5_weight_b", weight_o, mkdata(400, 0));
    pulse_release();

    // Protocol errors; state must be untouched by each ignored event.
    chk("t6_err_pre", err_o, 0);
    pulse_start();
    chk("t6_start_err", err_o, 1);
    chk("t6_start_ready", ready_o, 0);
    chk("t6_start_wvalid", weight_valid_o, 0);
    chk("t6_start_prep_ready", prepare_ready_o, 1);
    do_valid(mkdata(77, 0));
    chk("t6_stray_err", err_o, 1);
    chk("t6_stray_ready", ready_o, 0);
    chk("t6_stray_req", mem_if.request, 0);
    do_prepare(8'd1, 4'd1); do_valid(mkdata(500, 0));
    do_prepare(8'd2, 4'd1); do_valid(mkdata(600, 0));
    do_prepare(8'd9, 4'd9);
    chk("t6_full_err", err_o, 1);
    chk("t6_full_req", mem_if.request, 0);
    chk("t6_full_addr", mem_if.addr, 22);
    chk("t6_full_prep_ready", prepare_ready_o, 0);
    chk("t6_full_ready", ready_o, 1);
    pulse_start();
    chkw("t6_weight_first", weight_o, mkdata(500, 0));
    chk("t6_err_sticky", err_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
